// File: rtl/full_subtractor_pkg.sv
// rtl/full_subtractor_pkg.sv - shared constants for the full subtractor block
//
// Purpose: reset values and width limits used by the full subtractor slice.
// Ports:   none (package).
package full_subtractor_pkg;

  // Smallest legal operand width.
  localparam int FS_MIN_WIDTH = 1;

  // Reset value of the single-bit registered outputs.
  localparam logic FS_RST_BIT = 1'b0;

endpackage

// File: rtl/full_subtractor_cell.sv
// rtl/full_subtractor_cell.sv - one-bit combinational full subtractor cell
//
// Purpose: computes a - b - c for single bits.
// Ports:
//   a      in  minuend bit
//   b      in  subtrahend bit
//   c      in  borrow-in
//   diff   out difference bit
//   borrow out borrow-out
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b ^ c;
  // Borrow when the minuend bit is 0 and something is taken from it,
  // or when both b and the incoming borrow must be taken at once.
  assign borrow = (~a & (b | c)) | (b & c);

endmodule

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - registered ripple-borrow full subtractor
//
// Purpose: diff = a - b - c over WIDTH bits, registered with 1-cycle latency.
// Ports:
//   clk       in  system clock, rising edge
//   rst       in  asynchronous active-high reset
//   in_valid  in  a, b, c are valid this cycle
//   a         in  minuend [WIDTH]
//   b         in  subtrahend [WIDTH]
//   c         in  borrow-in
//   diff      out registered difference [WIDTH]
//   borrow    out registered borrow-out of the top bit
//   out_valid out one-cycle strobe marking a new result
module full_subtractor
  import full_subtractor_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             out_valid
);

  // chain[i] is the borrow into bit i; chain[WIDTH] is the final borrow-out.
  logic [WIDTH:0]   chain;
  logic [WIDTH-1:0] diff_comb;

  assign chain[0] = c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_subtractor_cell u_cell (
      .a      (a[i]),
      .b      (b[i]),
      .c      (chain[i]),
      .diff   (diff_comb[i]),
      .borrow (chain[i+1])
    );
  end

  // Results only update on accepted operands, so unknown inputs while
  // in_valid is low never reach the output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff      <= '0;
      borrow    <= FS_RST_BIT;
      out_valid <= FS_RST_BIT;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        diff   <= diff_comb;
        borrow <= chain[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_full_subtractor.sv
// tb/tb_full_subtractor.sv - self-checking bench for full_subtractor
module tb_full_subtractor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // WIDTH=1 instance
  logic       v1, a1, b1, c1, d1, bo1, ov1;
  // WIDTH=4 instance
  logic       v4, c4, bo4, ov4;
  logic [3:0] a4, b4, d4;
  // WIDTH=8 instance
  logic       v8, c8, bo8, ov8;
  logic [7:0] a8, b8, d8;

  full_subtractor #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .c(c1),
    .diff(d1), .borrow(bo1), .out_valid(ov1)
  );
  full_subtractor #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .c(c4),
    .diff(d4), .borrow(bo4), .out_valid(ov4)
  );
  full_subtractor #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .c(c8),
    .diff(d8), .borrow(bo8), .out_valid(ov8)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic [3:0] d;
    logic       bo;
  } vec_t;

  vec_t       t1[8];
  vec_t       t4[6];
  logic [8:0] exp_q[$];
  logic [8:0] e9;

  initial begin
    // Truth table of the one-bit subtractor: {a,b,c} -> {diff,borrow}
    t1[0] = '{4'd0, 4'd0, 1'b0, 4'd0, 1'b0};
    t1[1] = '{4'd0, 4'd0, 1'b1, 4'd1, 1'b1};
    t1[2] = '{4'd0, 4'd1, 1'b0, 4'd1, 1'b1};
    t1[3] = '{4'd0, 4'd1, 1'b1, 4'd0, 1'b1};
    t1[4] = '{4'd1, 4'd0, 1'b0, 4'd1, 1'b0};
    t1[5] = '{4'd1, 4'd0, 1'b1, 4'd0, 1'b0};
    t1[6] = '{4'd1, 4'd1, 1'b0, 4'd0, 1'b0};
    t1[7] = '{4'd1, 4'd1, 1'b1, 4'd1, 1'b1};
    // Multi-bit cases and boundaries for WIDTH=4
    t4[0] = '{4'h3, 4'h5, 1'b0, 4'hE, 1'b1};
    t4[1] = '{4'hF, 4'h0, 1'b1, 4'hE, 1'b0};
    t4[2] = '{4'h0, 4'hF, 1'b1, 4'h0, 1'b1};
    t4[3] = '{4'hF, 4'h0, 1'b0, 4'hF, 1'b0};
    t4[4] = '{4'h7, 4'h7, 1'b0, 4'h0, 1'b0};
    t4[5] = '{4'h9, 4'h9, 1'b1, 4'hF, 1'b1};

    rst = 1'b1;
    v1 = 0; a1 = 0; b1 = 0; c1 = 0;
    v4 = 0; a4 = 0; b4 = 0; c4 = 0;
    v8 = 0; a8 = 0; b8 = 0; c8 = 0;

    repeat (2) @(negedge clk);
    check("reset_diff_w8", {24'd0, d8}, 32'd0);
    check("reset_borrow_w8", {31'd0, bo8}, 32'd0);
    check("reset_valid_w1", {31'd0, ov1}, 32'd0);
    rst = 1'b0;

    // Exhaustive one-bit, back to back
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        check($sformatf("w1_valid_%0d", i - 1), {31'd0, ov1}, 32'd1);
        check($sformatf("w1_diff_%0d", i - 1), {31'd0, d1}, {28'd0, t1[i-1].d});
        check($sformatf("w1_borrow_%0d", i - 1), {31'd0, bo1}, {31'd0, t1[i-1].bo});
      end
      if (i < 8) begin
        v1 = 1'b1; a1 = t1[i].a[0]; b1 = t1[i].b[0]; c1 = t1[i].c;
      end else begin
        v1 = 1'b0;
      end
      @(negedge clk);
    end
    check("w1_valid_idle", {31'd0, ov1}, 32'd0);

    // Asynchronous reset between edges
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
    @(posedge clk);
    #2;
    check("pre_rst_diff", {31'd0, d1}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_async_diff", {31'd0, d1}, 32'd0);
    check("rst_async_borrow", {31'd0, bo1}, 32'd0);
    check("rst_async_valid", {31'd0, ov1}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_held_diff", {31'd0, d1}, 32'd0);
    check("rst_held_valid", {31'd0, ov1}, 32'd0);
    @(negedge clk);
    v1 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_diff", {31'd0, d1}, 32'd0);
    check("post_rst_valid", {31'd0, ov1}, 32'd0);

    // Hold while in_valid is low
    v1 = 1'b1; a1 = 1'b0; b1 = 1'b1; c1 = 1'b0;
    @(negedge clk);
    check("hold_load_diff", {31'd0, d1}, 32'd1);
    check("hold_load_borrow", {31'd0, bo1}, 32'd1);
    check("hold_load_valid", {31'd0, ov1}, 32'd1);
    v1 = 1'b0; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("hold_diff_%0d", k), {31'd0, d1}, 32'd1);
      check($sformatf("hold_borrow_%0d", k), {31'd0, bo1}, 32'd1);
      check($sformatf("hold_valid_%0d", k), {31'd0, ov1}, 32'd0);
    end

    // Four-bit table
    for (int i = 0; i <= 6; i++) begin
      if (i > 0) begin
        check($sformatf("w4_valid_%0d", i - 1), {31'd0, ov4}, 32'd1);
        check($sformatf("w4_diff_%0d", i - 1), {28'd0, d4}, {28'd0, t4[i-1].d});
        check($sformatf("w4_borrow_%0d", i - 1), {31'd0, bo4}, {31'd0, t4[i-1].bo});
      end
      if (i < 6) begin
        v4 = 1'b1; a4 = t4[i].a; b4 = t4[i].b; c4 = t4[i].c;
      end else begin
        v4 = 1'b0;
      end
      @(negedge clk);
    end

    // Eight-bit random regression against plain 9-bit arithmetic
    for (int i = 0; i <= 1000; i++) begin
      if (i > 0) begin
        e9 = exp_q.pop_front();
        check($sformatf("w8_valid_%0d", i - 1), {31'd0, ov8}, 32'd1);
        check($sformatf("w8_result_%0d", i - 1), {23'd0, bo8, d8}, {23'd0, e9});
      end
      if (i < 1000) begin
        v8 = 1'b1;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        c8 = 1'($urandom);
        exp_q.push_back({1'b0, a8} - {1'b0, b8} - {8'd0, c8});
      end else begin
        v8 = 1'b0;
      end
      @(negedge clk);
    end
    check("w8_valid_idle", {31'd0, ov8}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
